pipeline_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage core. Combines stall requests from ID, EX and MEM into the per-stage stall vector that holds the PC and the inter-stage registers (if_id and downstream). It also sequences exception/ERET redirects: it waits out MEM bus stalls, freezes the pipe, then issues a one-cycle flush with the redirect PC. A stall watchdog and a stall-cycle performance counter are included.

---
 rtl/pipeline_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall vector, exception/ERET redirect sequencing and stall watchdog
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024,
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_EXC_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [5:0] c_STALL_NONE = 6'b000000;
  localparam logic [5:0] c_STALL_ID   = 6'b000111;
  localparam logic [5:0] c_STALL_EX   = 6'b001111;
  localparam logic [5:0] c_STALL_MEM  = 6'b011111;
  localparam logic [5:0] c_STALL_ALL  = 6'b111111;

  state_t      r_state;
  logic [31:0] r_target;
  logic [15:0] r_stall_run;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic        r_stall_timeout;
  logic [31:0] r_stall_cycles;

  logic [5:0]  w_req_stall;
  logic [5:0]  w_stall;
  logic        w_any_req;
  logic        w_redirect_req;
  logic        w_accept;
  logic [31:0] w_sel_target;

  assign w_any_req      = stallreq_id | stallreq_ex | stallreq_mem;
  assign w_redirect_req = exc_valid | eret_valid;
  assign w_sel_target   = exc_valid ? EXC_VECTOR : cp0_epc;

  always_comb begin
    w_req_stall = c_STALL_NONE;
    if (stallreq_mem)      w_req_stall = c_STALL_MEM;
    else if (stallreq_ex)  w_req_stall = c_STALL_EX;
    else if (stallreq_id)  w_req_stall = c_STALL_ID;
  end

  // Acceptance: the redirect can proceed because MEM is no longer waiting on the bus
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      S_RUN:      w_accept = w_redirect_req & ~stallreq_mem;
      S_EXC_WAIT: w_accept = ~stallreq_mem;
      default:    w_accept = 1'b0;
    endcase
  end

  always_comb begin
    w_stall = w_req_stall;
    if (rst || (r_state == S_FLUSH)) w_stall = c_STALL_NONE;
    else if (w_accept)               w_stall = c_STALL_ALL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_RUN;
      r_target        <= 32'h0;
      r_flush         <= 1'b0;
      r_new_pc        <= 32'h0;
      r_stall_run     <= 16'h0;
      r_stall_timeout <= 1'b0;
      r_stall_cycles  <= 32'h0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_redirect_req) begin
            r_target <= w_sel_target;
            r_state  <= stallreq_mem ? S_EXC_WAIT : S_FLUSH;
          end
        end
        S_EXC_WAIT: begin
          if (!stallreq_mem) r_state <= S_FLUSH;
        end
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase

      r_flush <= w_accept;
      // In RUN the target is being latched this same cycle, so bypass the register
      if (w_accept) r_new_pc <= (r_state == S_RUN) ? w_sel_target : r_target;

      if (w_any_req) begin
        if (r_stall_run != 16'hFFFF) r_stall_run <= r_stall_run + 16'd1;
        if (r_stall_run == (STALL_TIMEOUT - 16'd1)) r_stall_timeout <= 1'b1;
      end else begin
        r_stall_run <= 16'h0;
      end

      if (w_stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall         = w_stall;
  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_stall_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed and randomized checks of pipeline_ctrl against a reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        exc_valid, eret_valid;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_wait;
  logic        m_flush;
  logic [31:0] m_tgt;
  logic [31:0] m_pc;
  int          m_run;
  logic        m_timeout;
  logic [31:0] m_cycles;

  pipeline_ctrl #(.STALL_TIMEOUT(16'd8), .EXC_VECTOR(32'h00000020)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] model_stall();
    if (rst || m_flush) return 6'b000000;
    if (!stallreq_mem && (m_wait || exc_valid || eret_valid)) return 6'b111111;
    if (stallreq_mem) return 6'b011111;
    if (stallreq_ex)  return 6'b001111;
    if (stallreq_id)  return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] sel_target();
    return exc_valid ? 32'h00000020 : cp0_epc;
  endfunction

  task automatic model_edge();
    logic [5:0] s;
    logic       acc;
    s = model_stall();
    if (rst) begin
      m_wait = 0; m_flush = 0; m_tgt = 0; m_pc = 0;
      m_run = 0; m_timeout = 0; m_cycles = 0;
    end else begin
      acc = (s == 6'b111111);
      if (acc) m_pc = m_wait ? m_tgt : sel_target();
      if (!m_flush && !m_wait && (exc_valid || eret_valid)) m_tgt = sel_target();
      if (m_flush)     m_wait = 0;
      else if (m_wait) m_wait = stallreq_mem;
      else             m_wait = (exc_valid || eret_valid) && stallreq_mem;
      if (s[0]) m_cycles = m_cycles + 1;
      if (stallreq_id || stallreq_ex || stallreq_mem) begin
        if (m_run == TO - 1) m_timeout = 1;
        if (m_run < 65535) m_run++;
      end else begin
        m_run = 0;
      end
      m_flush = acc;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    exc_valid = 0; eret_valid = 0; cp0_epc = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0; #2;
    total++; if (stall !== 6'b000000) begin bad++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b000000); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
    total++; if (new_pc !== 32'h0) begin bad++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL reset_cycles got=%0d exp=0", stall_cycles); end
    total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
    tick(); tick(); #2;
    total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL idle_cycles got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_priority();
    stallreq_id = 1; stallreq_ex = 1; #2;
    total++; if (stall !== 6'b001111) begin bad++; $display("FAIL prio_id_ex got=%b exp=%b", stall, 6'b001111); end
    tick();
    stallreq_mem = 1; #2;
    total++; if (stall !== 6'b011111) begin bad++; $display("FAIL prio_mem got=%b exp=%b", stall, 6'b011111); end
    tick();
    clear_inputs(); #2;
    total++; if (stall !== 6'b000000) begin bad++; $display("FAIL prio_none got=%b exp=%b", stall, 6'b000000); end
    total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL prio_cycles got=%0d exp=2", stall_cycles); end
    tick();
  endtask

  task automatic test_exception();
    exc_valid = 1; #2;
    total++; if (stall !== 6'b111111) begin bad++; $display("FAIL exc_accept_stall got=%b exp=%b", stall, 6'b111111); end
    tick();
    exc_valid = 0; #2;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL exc_flush got=%b exp=1", flush); end
    total++; if (new_pc !== 32'h00000020) begin bad++; $display("FAIL exc_new_pc got=%h exp=00000020", new_pc); end
    total++; if (stall !== 6'b000000) begin bad++; $display("FAIL exc_flush_stall got=%b exp=0", stall); end
    tick(); #2;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL exc_flush_end got=%b exp=0", flush); end
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL exc_cycles got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_eret_mem_stall();
    eret_valid = 1; cp0_epc = 32'h0000_1234; stallreq_mem = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (stall !== 6'b011111) begin bad++; $display("FAIL eret_wait%0d got=%b exp=%b", i, stall, 6'b011111); end
      tick();
      cp0_epc = 32'hDEAD_0000;
    end
    eret_valid = 0; stallreq_mem = 0; #2;
    total++; if (stall !== 6'b111111) begin bad++; $display("FAIL eret_accept got=%b exp=%b", stall, 6'b111111); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL eret_early_flush got=%b exp=0", flush); end
    tick(); #2;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL eret_flush got=%b exp=1", flush); end
    total++; if (new_pc !== 32'h0000_1234) begin bad++; $display("FAIL eret_new_pc got=%h exp=00001234", new_pc); end
    tick(); #2;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL eret_flush_end got=%b exp=0", flush); end
  endtask

  task automatic test_simultaneous();
    exc_valid = 1; eret_valid = 1; cp0_epc = 32'h5555_AAAA; #2;
    total++; if (stall !== 6'b111111) begin bad++; $display("FAIL simul_accept got=%b exp=%b", stall, 6'b111111); end
    tick();
    clear_inputs(); #2;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL simul_flush got=%b exp=1", flush); end
    total++; if (new_pc !== 32'h00000020) begin bad++; $display("FAIL simul_new_pc got=%h exp=00000020", new_pc); end
    tick();
  endtask

  task automatic test_reset_abandon();
    exc_valid = 1; stallreq_mem = 1;
    tick();
    exc_valid = 0;
    tick();
    rst = 1; stallreq_mem = 0;
    tick();
    rst = 0; #2;
    total++; if (stall !== 6'b000000) begin bad++; $display("FAIL abandon_stall got=%b exp=0", stall); end
    tick(); #2;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL abandon_flush got=%b exp=0", flush); end
  endtask

  task automatic test_watchdog();
    stallreq_ex = 1;
    for (int i = 0; i < 8; i++) begin
      #2;
      total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL wd_early%0d got=%b exp=0", i, stall_timeout); end
      tick();
    end
    #2;
    total++; if (stall_timeout !== 1'b1) begin bad++; $display("FAIL wd_set got=%b exp=1", stall_timeout); end
    stallreq_ex = 0;
    tick(); tick(); #2;
    total++; if (stall_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", stall_timeout); end
    rst = 1; tick(); rst = 0; #2;
    total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL wd_reset got=%b exp=0", stall_timeout); end
    for (int b = 0; b < 2; b++) begin
      stallreq_id = 1;
      repeat (7) tick();
      stallreq_id = 0;
      tick(); #2;
      total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL wd_burst7_%0d got=%b exp=0", b, stall_timeout); end
    end
  endtask

  task automatic test_random();
    logic [5:0] es;
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 4) == 0);
      stallreq_mem = ($urandom_range(0, 2) == 0);
      exc_valid    = ($urandom_range(0, 7) == 0);
      eret_valid   = ($urandom_range(0, 7) == 0);
      cp0_epc      = $urandom;
      #2;
      es = model_stall();
      total++; if (stall !== es) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, es); end
      total++; if (flush !== m_flush) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, flush, m_flush); end
      if (m_flush) begin
        total++; if (new_pc !== m_pc) begin bad++; $display("FAIL rnd_new_pc cyc=%0d got=%h exp=%h", i, new_pc, m_pc); end
      end
      total++; if (stall_timeout !== m_timeout) begin bad++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", i, stall_timeout, m_timeout); end
      total++; if (stall_cycles !== m_cycles) begin bad++; $display("FAIL rnd_cycles cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cycles); end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    m_wait = 0; m_flush = 0; m_tgt = 0; m_pc = 0;
    m_run = 0; m_timeout = 0; m_cycles = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_priority();
    test_exception();
    test_eret_mem_stall();
    test_simultaneous();
    test_reset_abandon();
    test_watchdog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
